usb_tx_arbiter: RTL

//  Shares the single USB TX packet path (usb_tx_fsm) among NUM_REQ requesters, e.g. the

---
 rtl/usb_tx_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: shares the single USB TX packet path among NUM_REQ requesters.
// Handshake PIDs (ACK/NAK/STALL) take priority over data PIDs (DATA0/DATA1).
// Each class has its own round-robin pointer.
// Every packet is followed by a forced inter-packet gap.
// Start and transfer watchdogs abort stuck packets.

// Per-requester decode: splits a request into handshake or data eligibility.
module usb_tx_arb_lane (
    input  logic       req,
    input  logic [2:0] pid,
    output logic       hs,
    output logic       dt
);
    assign hs = req && (pid >= 3'd3) && (pid <= 3'd5);
    assign dt = req && ((pid == 3'd1) || (pid == 3'd2));
endmodule

module usb_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IPG_CYC  = 16,
    parameter int START_TO = 64,
    parameter int PKT_TO   = 65535
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] req_pid,
    input  logic                 tx_transfer_active,
    input  logic                 packet_done,
    output logic [2:0]           tx_packet,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 timeout_err,
    output logic                 busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(PKT_TO + 1);
    localparam logic [CW-1:0] ISSUE_LIM = CW'(START_TO - 1);
    localparam logic [CW-1:0] XFER_LIM  = CW'(PKT_TO - 1);
    localparam logic [CW-1:0] GAP_LIM   = CW'(IPG_CYC - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, ABORT, GAP} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt;
    logic [NUM_REQ-1:0][2:0]   pid_arr;
    logic [NUM_REQ-1:0]        hs_elig, dt_elig, cand;
    logic                      use_hs, pick_any;
    logic [IW-1:0]             ptr, j, pick_idx;
    logic [IW-1:0]             rr_hs, rr_dt, win;
    logic                      win_hs;
    logic [2:0]                tx_packet_nx;
    logic [NUM_REQ-1:0]        grant_nx, done_nx;

    assign pid_arr = req_pid;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        usb_tx_arb_lane u_lane (
            .req (req[i]),
            .pid (pid_arr[i]),
            .hs  (hs_elig[i]),
            .dt  (dt_elig[i])
        );
    end

    // Pick the first eligible requester of the winning class after its RR pointer.
    always_comb begin
        use_hs   = |hs_elig;
        cand     = use_hs ? hs_elig : dt_elig;
        ptr      = use_hs ? rr_hs : rr_dt;
        pick_any = 1'b0;
        pick_idx = '0;
        j        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (!pick_any && cand[j]) begin
                pick_any = 1'b1;
                pick_idx = j;
            end
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (pick_any) state_nx = ISSUE;
            ISSUE: if (tx_transfer_active) state_nx = BUSY;
                   else if (cnt == ISSUE_LIM) state_nx = ABORT;
            BUSY:  if (packet_done) state_nx = DONE;
                   else if (cnt == XFER_LIM) state_nx = ABORT;
            DONE:  state_nx = GAP;
            ABORT: state_nx = GAP;
            GAP:   if (cnt == GAP_LIM) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        grant_nx     = grant;
        tx_packet_nx = '0;
        if (state == IDLE && state_nx == ISSUE) begin
            grant_nx           = '0;
            grant_nx[pick_idx] = 1'b1;
            tx_packet_nx       = pid_arr[pick_idx];
        end else if (state_nx == ISSUE) begin
            tx_packet_nx = tx_packet;
        end else if (state_nx == IDLE) begin
            grant_nx = '0;
        end
        done_nx = (state_nx == DONE) ? grant : '0;
    end

    // State register with a shared saturating counter cleared on every state entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) cnt <= '0;
            else if (cnt != '1)    cnt <= cnt + 1'b1;
        end
    end

    // Winner latch and round-robin pointers; pointers move on both completion and abort.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win    <= '0;
            win_hs <= 1'b0;
            rr_hs  <= IW'(NUM_REQ - 1);
            rr_dt  <= IW'(NUM_REQ - 1);
        end else begin
            if (state == IDLE && pick_any) begin
                win    <= pick_idx;
                win_hs <= use_hs;
            end
            if (state == DONE || state == ABORT) begin
                if (win_hs) rr_hs <= win;
                else        rr_dt <= win;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_packet   <= '0;
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_packet   <= tx_packet_nx;
            grant       <= grant_nx;
            done        <= done_nx;
            timeout_err <= (state_nx == ABORT);
            busy        <= (state_nx != IDLE);
        end
    end
endmodule
